// File: rtl/sysid_info_regs_pkg.sv
// Shared constants for the sysid_info_regs block: register map, CTRL/STATUS
// bit positions, CAPS field layout, and small helpers for CAPS packing and
// byte-masked writes.
package sysid_pkg;

  // Word addresses
  localparam logic [3:0] ADDR_ID        = 4'd0;
  localparam logic [3:0] ADDR_TS        = 4'd1;
  localparam logic [3:0] ADDR_CAPS      = 4'd2;
  localparam logic [3:0] ADDR_CTRL      = 4'd3;
  localparam logic [3:0] ADDR_UPTIME_LO = 4'd4;
  localparam logic [3:0] ADDR_UPTIME_HI = 4'd5;
  localparam logic [3:0] ADDR_ALARM_CMP = 4'd6;
  localparam logic [3:0] ADDR_STATUS    = 4'd7;
  localparam logic [3:0] ADDR_SCRATCH0  = 4'd8;

  // CTRL bits
  localparam int CTRL_CNT_EN = 0;
  localparam int CTRL_CLR    = 1;

  // STATUS bits
  localparam int STATUS_ALARM  = 0;
  localparam int STATUS_IRQ_EN = 1;

  // CAPS fields
  localparam int CAPS_NSCR_LSB  = 0;
  localparam int CAPS_NSCR_W    = 4;
  localparam int CAPS_CNTW_LSB  = 8;
  localparam int CAPS_CNTW_W    = 7;
  localparam int CAPS_ALARM_BIT = 16;

  // Build the read-only capability word from the elaboration parameters.
  function automatic logic [31:0] pack_caps(input int num_scratch,
                                            input int cnt_w,
                                            input bit alarm_present);
    logic [31:0] caps;
    logic [31:0] nscr;
    logic [31:0] cntw;
    caps = '0;
    nscr = num_scratch;
    cntw = cnt_w;
    caps[CAPS_NSCR_LSB +: CAPS_NSCR_W] = nscr[CAPS_NSCR_W-1:0];
    caps[CAPS_CNTW_LSB +: CAPS_CNTW_W] = cntw[CAPS_CNTW_W-1:0];
    caps[CAPS_ALARM_BIT]               = alarm_present;
    return caps;
  endfunction

  // Replace only the byte lanes enabled in be.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sysid_info_regs_if.sv
// Avalon-MM slave bus bundle for sysid_info_regs (fixed latency 1, no
// waitrequest). clock/reset and irq are carried as plain ports.
interface sysid_info_regs_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_uptime_ctr.sv
// Free-running uptime counter with enable, synchronous clear and a HI-word
// shadow captured on every UPTIME_LO read so a LO-then-HI read pair is atomic.
module sysid_uptime_ctr #(
  parameter int CNT_W = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_we,   // CTRL register write accepted this cycle
  input  logic        wr_en,     // CNT_EN value being written
  input  logic        wr_clr,    // CLR bit being written
  input  logic        lo_rd,     // UPTIME_LO read accepted this cycle
  output logic        cnt_en,
  output logic [31:0] cnt_lo,
  output logic [31:0] hi_shadow
);

  localparam int HI_W = CNT_W - 32;

  logic [CNT_W-1:0] cnt_q;
  logic [HI_W-1:0]  shadow_q;
  logic             en_q;
  logic             clr;

  assign clr = ctrl_we && wr_clr;

  // Counter: clear beats increment; wraps silently at 2^CNT_W-1.
  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       cnt_q <= '0;
    else if (clr)    cnt_q <= '0;
    else if (en_q)   cnt_q <= cnt_q + 1'b1;
  end

  // Enable bit of CTRL; comes out of reset counting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        en_q <= 1'b1;
    else if (ctrl_we) en_q <= wr_en;
  end

  // HI shadow latches the upper word on the same edge that returns LO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      shadow_q <= '0;
    else if (lo_rd) shadow_q <= cnt_q[CNT_W-1:32];
  end

  assign cnt_en    = en_q;
  assign cnt_lo    = cnt_q[31:0];
  assign hi_shadow = 32'(shadow_q);

endmodule

// File: rtl/sysid_info_regs.sv
// System-ID / build-info register block on an Avalon-MM slave.
// Optional alarm comparator and interrupt enabled by defining SYSID_ALARM_EN.
module sysid_info_regs
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYS_ID      = 32'h606A_0000,
  parameter logic [31:0] BUILD_TS    = 32'h0000_0000,
  parameter int          NUM_SCRATCH = 2,
  parameter int          CNT_W       = 64,
  parameter int          ADDR_W      = 4
) (
  input  logic               clock,
  input  logic               reset,
  sysid_info_regs_if.slave   bus,
  output logic               irq
);

`ifdef SYSID_ALARM_EN
  localparam bit ALARM_PRESENT = 1'b1;
`else
  localparam bit ALARM_PRESENT = 1'b0;
`endif

  localparam logic [31:0] CAPS  = pack_caps(NUM_SCRATCH, CNT_W, ALARM_PRESENT);
  localparam int          SCR_N = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;

  logic [ADDR_W-1:0] addr;
  logic              ctrl_we;
  logic              lo_rd;
  logic              cnt_en;
  logic [31:0]       cnt_lo;
  logic [31:0]       hi_shadow;
  logic [31:0]       scratch_q [SCR_N];
  logic [31:0]       scratch_rd;
  logic [31:0]       alarm_cmp_rd;
  logic [31:0]       status_rd;
  logic [31:0]       rd_mux;
  logic [31:0]       readdata_q;
  logic              rdv_q;

  assign addr    = bus.address;
  assign ctrl_we = bus.write && (addr == ADDR_CTRL);
  assign lo_rd   = bus.read  && (addr == ADDR_UPTIME_LO);

  sysid_uptime_ctr #(
    .CNT_W (CNT_W)
  ) u_ctr (
    .clock     (clock),
    .reset     (reset),
    .ctrl_we   (ctrl_we),
    .wr_en     (bus.writedata[CTRL_CNT_EN]),
    .wr_clr    (bus.writedata[CTRL_CLR]),
    .lo_rd     (lo_rd),
    .cnt_en    (cnt_en),
    .cnt_lo    (cnt_lo),
    .hi_shadow (hi_shadow)
  );

  // Scratch registers: byte-masked writes, cleared on reset.
  // NOTE: these are a few discrete flops rather than a RAM macro, so they
  // take the async reset like any other register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SCR_N; i++) scratch_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (bus.write && (addr == ADDR_SCRATCH0 + 4'(i)))
          scratch_q[i] <= be_merge(scratch_q[i], bus.writedata, bus.byteenable);
      end
    end
  end

  // Scratch read-back; anything outside the populated window reads 0.
  always_comb begin
    scratch_rd = '0;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (addr == ADDR_SCRATCH0 + 4'(i)) scratch_rd = scratch_q[i];
    end
  end

`ifdef SYSID_ALARM_EN
  logic [31:0] alarm_cmp_q;
  logic        alarm_q;
  logic        irq_en_q;
  logic        irq_q;
  logic        status_we;
  logic        alarm_set;
  logic        alarm_clr;

  assign status_we = bus.write && (addr == ADDR_STATUS) && bus.byteenable[0];
  assign alarm_set = cnt_en && (cnt_lo == alarm_cmp_q);
  assign alarm_clr = status_we && bus.writedata[STATUS_ALARM];

  // Alarm compare, sticky W1C flag (set beats clear) and registered irq.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alarm_cmp_q <= '0;
      alarm_q     <= 1'b0;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      if (bus.write && (addr == ADDR_ALARM_CMP))
        alarm_cmp_q <= be_merge(alarm_cmp_q, bus.writedata, bus.byteenable);
      if (status_we)
        irq_en_q <= bus.writedata[STATUS_IRQ_EN];
      alarm_q <= alarm_set | (alarm_q & ~alarm_clr);
      irq_q   <= alarm_q & irq_en_q;
    end
  end

  assign alarm_cmp_rd = alarm_cmp_q;
  assign status_rd    = {30'b0, irq_en_q, alarm_q};
  assign irq          = irq_q;
`else
  assign alarm_cmp_rd = '0;
  assign status_rd    = '0;
  assign irq          = 1'b0;
`endif

  // Register read mux.
  // NOTE: rd_mux gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_ID:        rd_mux = SYS_ID;
      ADDR_TS:        rd_mux = BUILD_TS;
      ADDR_CAPS:      rd_mux = CAPS;
      ADDR_CTRL:      rd_mux = {30'b0, 1'b0, cnt_en};
      ADDR_UPTIME_LO: rd_mux = cnt_lo;
      ADDR_UPTIME_HI: rd_mux = hi_shadow;
      ADDR_ALARM_CMP: rd_mux = alarm_cmp_rd;
      ADDR_STATUS:    rd_mux = status_rd;
      default:        rd_mux = scratch_rd;
    endcase
  end

  // Registered read response; readdata holds between reads, and a read
  // caught by reset never produces a valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      readdata_q <= '0;
      rdv_q      <= 1'b0;
    end else begin
      rdv_q <= bus.read;
      if (bus.read) readdata_q <= rd_mux;
    end
  end

  assign bus.readdata      = readdata_q;
  assign bus.readdatavalid = rdv_q;

endmodule

// File: doc/sysid_info_regs.md
Name: sysid_info_regs

Overview:
- Parametrised system-ID and build-info register block on an Avalon-MM slave; next generation of the fixed two-word sysid peripheral.
- Returns ID and build timestamp, plus a capability word, a free-running uptime counter with atomic 64-bit read, control/status, and NUM_SCRATCH read/write scratch words.
- Sits on the HPS/Nios lightweight bus; software uses it to check the loaded bitstream and to measure elapsed time.

Parameters:
- SYS_ID, 32'h606A_0000, system ID word returned at address 0.
- BUILD_TS, 32'h0000_0000, build timestamp (Unix seconds) returned at address 1.
- NUM_SCRATCH, 2, number of 32-bit scratch registers; legal 0..8.
- CNT_W, 64, uptime counter width; legal 33..64; upper word zero-extended.
- ADDR_W, 4, word-address width; fixed at 4 (16 words).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- address  in  ADDR_W  word address
- read  in  1  read strobe, one cycle per access
- write  in  1  write strobe, one cycle per access
- writedata  in  32  write data
- byteenable  in  4  byte lanes for write; applies to scratch and alarm registers only
- readdata  out  32  read data, registered
- readdatavalid  out  1  pulses one cycle after an accepted read
- irq  out  1  alarm interrupt, level

Behaviour:
- Map:
  - 0 ID (RO)
  - 1 TS (RO)
  - 2 CAPS (RO): [3:0] NUM_SCRATCH, [14:8] CNT_W, [16] alarm present
  - 3 CTRL (RW): bit0 CNT_EN, reset 1; bit1 CLR, write-1 pulse, reads 0
  - 4 UPTIME_LO (RO)
  - 5 UPTIME_HI (RO, shadow)
  - 6 ALARM_CMP
  - 7 STATUS
  - 8..8+NUM_SCRATCH-1 scratch (RW, reset 0)
  - All other addresses read 0; writes to them and to RO registers are ignored.
- Reads:
  - Fixed latency 1: read at edge N gives readdatavalid=1 with readdata valid after edge N+1.
  - No waitrequest.
  - readdata holds its last value when readdatavalid=0.
- Read and write in the same cycle are both honoured; the read returns the pre-write value.
- Counter:
  - Increments by 1 every clock while CNT_EN=1.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
  - CLR zeroes the counter on the edge the write is accepted; CLR has priority over increment in the same cycle.
- Atomic read:
  - A read of UPTIME_LO returns counter[31:0] as sampled on the accepting edge.
  - On that same edge, counter[CNT_W-1:32] is copied into the HI shadow.
  - A read of UPTIME_HI returns the shadow, which changes only on a LO read.
  - Shadow reset value is 0.
- Reset:
  - All registers cleared asynchronously: readdata=0, readdatavalid=0, irq=0, counter=0, shadow=0, scratch=0, CNT_EN=1.
  - A read pending when reset asserts is dropped; no readdatavalid follows.
- Scratch writes are byte-masked by byteenable. With NUM_SCRATCH=0 the scratch window reads 0.

Optional Feature:
- Macro: SYSID_ALARM_EN.
- With SYSID_ALARM_EN defined:
  - ALARM_CMP is a 32-bit RW register, reset 0, byte-masked.
  - STATUS bit0 ALARM sets when CNT_EN=1 and counter[31:0]==ALARM_CMP on an edge; it is sticky and cleared by writing 1.
  - If set and clear occur in the same cycle, set wins.
  - STATUS bit1 IRQ_EN, reset 0. irq = ALARM & IRQ_EN, registered.
  - CAPS[16]=1.
- Without it: addresses 6 and 7 read 0 and ignore writes, irq is tied 0, CAPS[16]=0.

Decomposition:
- Package sysid_pkg holds:
  - address constants (ADDR_ID .. ADDR_SCRATCH0)
  - CTRL and STATUS bit indices
  - the CAPS field positions
  - a function that packs CAPS from the parameters.
- One sub-module, sysid_uptime_ctr, holds the counter, enable, clear and HI shadow latch. The top holds the decode, the read-data register, scratch and alarm.

Test Plan:
- Reset, then read addresses 0, 1 and 2 with defaults -> 32'h606A_0000, 32'h0000_0000 and 32'h0000_4002 respectively (CAPS[16]=0 when SYSID_ALARM_EN is not defined; 32'h0001_4002 when it is), each with readdatavalid exactly one cycle after read.
- Write scratch 8 = 32'hDEAD_BEEF, then write 32'h0000_00AA with byteenable 4'b0001 -> read returns 32'hDEAD_BEAA; a write to address 0 leaves the ID unchanged.
- Force counter to 64'h0000_0001_FFFF_FFFF, read LO -> 32'hFFFF_FFFF; wait 10 cycles, read HI -> 32'h0000_0001 (shadow, not live 2); the next LO read updates HI to 2.
- Write CTRL=0, read LO twice 20 cycles apart -> equal values; write CTRL=3 (enable plus clear) -> the next LO read returns a small value under 5.
- Write CTRL=2 in the same cycle the counter would increment -> counter is 0 on the next edge; assert reset mid-read -> no readdatavalid, all outputs 0.
- SYSID_ALARM_EN: ALARM_CMP=100, IRQ_EN=1, clear counter -> irq rises 2 cycles after counter[31:0] equals 100; write STATUS=3 -> irq drops; when set and clear coincide, ALARM stays 1.
